mul32_operand_packer: RTL and testbench
=======================================

# mul32_operand_packer

Front-end issuer for the 32-bit byte-sliced multiplier. It accepts 32-bit operand pairs over a valid/ready handshake and buffers them in a small FIFO. It packs each pair into the 64-bit byte-lane bus that the middle partial-product stages consume, and holds the bus stable until the downstream stage accepts it. It is the writer side of the `Input` bus that feeds every `mulMiddle_*` stage.

## Interface
Parameters:
- `DEPTH`, 2 — operand FIFO entries; legal values are 2, 4 or 8.
- `CNT_W`, 16 — width of the issued-transaction counter.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `in_valid` in 1 — upstream presents an operand pair.
- `in_ready` out 1 — packer can accept a pair this cycle.
- `in_a` in 32 — multiplicand A.
- `in_b` in 32 — multiplier B.
- `out_valid` out 1 — `Output` holds a packed pair.
- `out_ready` in 1 — downstream middle stage accepts this cycle.
- `Output` out 64 — packed operand bus.
- `issue_count` out `CNT_W` — number of pairs accepted downstream; wraps.
- `out_zero` out 1 — present only with `MUL32_PACKER_ZERO_FLAG_EN`.

## Operation
- Packing:
  - `Output[8k+7:8k] = in_a[8k+7:8k]` for k = 0..3.
  - `Output[8(k+4)+7:8(k+4)] = in_b[8k+7:8k]` for k = 0..3.
  - Equivalently, `Output = {in_b, in_a}`. Packing is done at enqueue time and stored packed.
- FIFO: circular buffer of `DEPTH` 64-bit entries with write pointer, read pointer and occupancy count (log2(DEPTH)+1 bits). Pointers wrap modulo `DEPTH`.
- Enqueue when `in_valid && in_ready`.
  - `in_ready = (count < DEPTH) || (out_valid && out_ready)`. A full FIFO accepts when it is popping in the same cycle.
- Dequeue when `out_valid && out_ready`.
  - `out_valid = (count != 0)`.
  - `Output` = head entry, driven directly from storage with no extra register.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This also holds at full.
- Empty FIFO: there is no fall-through. A pair enqueued at cycle N is visible on `Output` at cycle N+1.
- While `out_valid && !out_ready`, `Output` and `out_valid` stay stable.
- `Output` is don't-care while `out_valid = 0`. The implementation drives 64'd0 in that case.
- `issue_count` increments by 1 on each dequeue and wraps from 2^CNT_W−1 to 0.
- State machine, derived from count:
  - EMPTY (count = 0).
  - PARTIAL (0 < count < DEPTH).
  - FULL (count = DEPTH).
  - Transitions follow the enqueue/dequeue rules above; enqueue and dequeue together leave the state unchanged.

## Timing
- Reset values: `out_valid = 0`, `in_ready = 1`, `Output = 0`, `issue_count = 0`, `out_zero = 0`. Pointers and count are 0.
- Latency is 1 cycle from accepted input to `out_valid`. Throughput is 1 pair per cycle when `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready`. `out_valid` and `Output` have no combinational path from `in_*`.
- Reset asserted mid-stream:
  - All queued pairs are dropped at the next edge.
  - Handshakes in the reset cycle are ignored; no enqueue, dequeue or count increment occurs.
  - `in_ready = 1` takes effect from the first cycle after reset.

## Configuration
- `MUL32_PACKER_ZERO_FLAG_EN` defined:
  - Each FIFO entry stores an extra bit, set at enqueue to `(in_a == 0) || (in_b == 0)`.
  - `out_zero` reflects the head entry's bit, qualified by `out_valid`; it reads 0 when empty.
  - Downstream stages use it to skip partial-product computation.
- Macro undefined: the `out_zero` port and the stored bit are absent. All other behaviour is identical.

## Test plan
- Reset then single pair: A=0x04030201, B=0x08070605 with `out_ready` high.
  - One cycle later, `out_valid = 1` and `Output = 0x0807060504030201`.
  - `issue_count` = 1 after the handshake.
- Backpressure fill, `DEPTH` = 2, `out_ready = 0`: push 0x11/0x22, 0x33/0x44, 0x55/0x66.
  - Third push sees `in_ready = 0`.
  - `Output` holds 0x0000002200000011 stable for 5 cycles.
- Full plus simultaneous pop/push: with the FIFO full, raise `out_ready` and push 0x55/0x66 in the same cycle.
  - Enqueue is accepted and count stays 2.
  - Drain order is 0x…11, 0x…33, 0x…55.
- Streaming 1000 random pairs with random `out_ready` (50%):
  - Outputs match the `{B, A}` scoreboard in order.
  - `issue_count` = 1000.
- Mid-stream reset with 2 entries queued:
  - Next cycle: `out_valid = 0`, `in_ready = 1`, `issue_count = 0`.
  - Next pair appears alone on `Output`.
- With `MUL32_PACKER_ZERO_FLAG_EN`:
  - A=0, B=0xFFFFFFFF gives `out_zero = 1`.
  - A=1, B=1 gives `out_zero = 0`.
  - Empty FIFO gives `out_zero = 0`.

Source files
------------

// File: rtl/mul32_operand_packer.sv
// -----------------------------------------------------------------------------
// mul32_operand_packer
//
// Front-end issuer for the 32-bit byte-sliced multiplier. It accepts operand
// pairs over a valid/ready handshake and packs each pair as {in_b, in_a} into
// a 64-bit byte-lane word. The packed words are buffered in a DEPTH-entry
// circular FIFO. The head entry drives the Output bus until the downstream
// middle stage accepts it.
//
// Parameters:
//   DEPTH  - FIFO entries (2, 4 or 8)
//   CNT_W  - width of the issued-transaction counter
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   in_valid/in_ready, in_a, in_b   - upstream operand handshake
//   out_valid/out_ready, Output     - packed bus towards mulMiddle_* stages
//   issue_count   - number of pairs accepted downstream (wraps)
//   out_zero      - head entry has a zero operand (only when the macro
//                   MUL32_PACKER_ZERO_FLAG_EN is defined)
// -----------------------------------------------------------------------------
module mul32_operand_packer #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      Output,
    output logic [CNT_W-1:0] issue_count
`ifdef MUL32_PACKER_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    state_t             state_reg, state_next;
    logic [OCC_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   issue_count_reg;

    logic [63:0]        mem [DEPTH];
    logic [63:0]        packed_word;
    logic               enq;
    logic               deq;

    // Byte lanes 0..3 carry A, lanes 4..7 carry B.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign packed_word[8*gi +: 8]      = in_a[8*gi +: 8];
            assign packed_word[32 + 8*gi +: 8] = in_b[8*gi +: 8];
        end
    endgenerate

    // The FULL state mirrors count == DEPTH, so in_ready can be taken from
    // the state register. A full FIFO still accepts when it pops this cycle.
    assign out_valid = (state_reg != ST_EMPTY);
    assign deq       = out_valid && out_ready;
    assign in_ready  = (state_reg != ST_FULL) || deq;
    assign enq       = in_valid && in_ready;

    // The head entry is read straight from storage, with no output register.
    assign Output      = out_valid ? mem[rd_ptr_reg] : 64'd0;
    assign issue_count = issue_count_reg;

    always_comb begin
        count_next = count_reg;
        state_next = state_reg;
        if (enq && !deq) begin
            count_next = count_reg + OCC_W'(1);
        end else if (deq && !enq) begin
            count_next = count_reg - OCC_W'(1);
        end
        if (count_next == '0) begin
            state_next = ST_EMPTY;
        end else if (count_next == DEPTH_OCC) begin
            state_next = ST_FULL;
        end else begin
            state_next = ST_PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_EMPTY;
            count_reg       <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            issue_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_reg      <= rd_ptr_reg + PTR_W'(1);
                issue_count_reg <= issue_count_reg + CNT_W'(1);
            end
        end
    end

    // Storage has no reset; stale contents are never visible because Output
    // is gated by out_valid.
    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            mem[wr_ptr_reg] <= packed_word;
        end
    end

`ifdef MUL32_PACKER_ZERO_FLAG_EN
    logic zero_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            zero_mem[wr_ptr_reg] <= (in_a == 32'd0) || (in_b == 32'd0);
        end
    end

    assign out_zero = out_valid && zero_mem[rd_ptr_reg];
`endif

endmodule

// File: tb/tb_mul32_operand_packer.sv
module tb_mul32_operand_packer;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      Output;
    logic [CNT_W-1:0] issue_count;
`ifdef MUL32_PACKER_ZERO_FLAG_EN
    logic             out_zero;
`endif

    int checks = 0;
    int errors = 0;

    mul32_operand_packer #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Output     (Output),
        .issue_count(issue_count)
`ifdef MUL32_PACKER_ZERO_FLAG_EN
        ,
        .out_zero   (out_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (Output !== 64'd0) begin
            errors++; $display("FAIL reset_output: got %h expected 0", Output);
        end
        checks++;
        if (issue_count !== 16'd0) begin
            errors++; $display("FAIL reset_issue_count: got %0d expected 0", issue_count);
        end
        $display("reset: out_valid=%b in_ready=%b Output=%h issue_count=%0d",
                 out_valid, in_ready, Output, issue_count);
    endtask

    task automatic test_single();
        do_reset();
        in_valid  = 1'b1;
        in_a      = 32'h04030201;
        in_b      = 32'h08070605;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL single_out_valid: got %b expected 1", out_valid);
        end
        checks++;
        if (Output !== 64'h0807060504030201) begin
            errors++; $display("FAIL single_output: got %h expected 0807060504030201", Output);
        end
        $display("single: Output=%h", Output);
        tick();
        checks++;
        if (issue_count !== 16'd1) begin
            errors++; $display("FAIL single_issue_count: got %0d expected 1", issue_count);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_drained: got %b expected 0", out_valid);
        end
    endtask

    // Leaves the FIFO full (0x11/0x22, 0x33/0x44) for test_full_pop_push.
    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 32'h11; in_b = 32'h22;
        tick();
        in_a = 32'h33; in_b = 32'h44;
        tick();
        in_a = 32'h55; in_b = 32'h66;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready_full: got %b expected 0", in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || Output !== 64'h0000002200000011) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b %h expected valid=1 0000002200000011",
                         i, out_valid, Output);
            end
            $display("backpressure cycle %0d: Output=%h", i, Output);
            tick();
        end
    endtask

    task automatic test_full_pop_push();
        logic [63:0] exp_out [3];
        exp_out[0] = 64'h0000002200000011;
        exp_out[1] = 64'h0000004400000033;
        exp_out[2] = 64'h0000006600000055;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = 32'h55; in_b = 32'h66;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL full_pop_push_in_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        // Count must still be 2, so the FIFO reports full.
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL full_after_pop_push: in_ready got %b expected 0", in_ready);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || Output !== exp_out[i]) begin
                errors++;
                $display("FAIL drain[%0d]: got valid=%b %h expected valid=1 %h",
                         i, out_valid, Output, exp_out[i]);
            end
            $display("drain %0d: Output=%h", i, Output);
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty: got %b expected 0", out_valid);
        end
        checks++;
        if (issue_count !== 16'd3) begin
            errors++; $display("FAIL drain_issue_count: got %0d expected 3", issue_count);
        end
    endtask

    task automatic test_stream();
        logic [63:0] q[$];
        logic [63:0] exp;
        logic        exp_rdy;
        int sent = 0;
        int recv = 0;
        int cycles = 0;
        do_reset();
        while (recv < 1000 && cycles < 20000) begin
            in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
            in_a      = $urandom;
            in_b      = $urandom;
            out_ready = 1'($urandom_range(1));
            #1;
            checks++;
            if (out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL stream_out_valid: got %b expected %b", out_valid, q.size() != 0);
            end
            exp_rdy = (q.size() < DEPTH) || ((q.size() != 0) && out_ready);
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL stream_in_ready: got %b expected %b", in_ready, exp_rdy);
            end
            if (out_valid && out_ready) begin
                exp = (q.size() != 0) ? q.pop_front() : 64'd0;
                checks++;
                if (Output !== exp) begin
                    errors++; $display("FAIL stream_data[%0d]: got %h expected %h", recv, Output, exp);
                end
                $display("stream pop %0d: Output=%h", recv, Output);
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_b, in_a});
                sent++;
            end
            tick();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (recv != 1000) begin
            errors++; $display("FAIL stream_timeout: received %0d expected 1000", recv);
        end
        checks++;
        if (issue_count !== 16'd1000) begin
            errors++; $display("FAIL stream_issue_count: got %0d expected 1000", issue_count);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 32'hA1; in_b = 32'hB1;
        tick();
        in_a = 32'hA2; in_b = 32'hB2;
        tick();
        // Handshakes during the reset cycle must be ignored.
        rst       = 1'b1;
        in_a      = 32'hDEAD0000; in_b = 32'hBEEF0000;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (issue_count !== 16'd0) begin
            errors++; $display("FAIL midrst_issue_count: got %0d expected 0", issue_count);
        end
        in_valid = 1'b1;
        in_a = 32'hAAAA5555; in_b = 32'h12345678;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || Output !== 64'h12345678AAAA5555) begin
            errors++;
            $display("FAIL midrst_next_pair: got valid=%b %h expected valid=1 12345678aaaa5555",
                     out_valid, Output);
        end
        $display("midreset: next Output=%h", Output);
        tick();
        checks++;
        if (out_valid !== 1'b0 || issue_count !== 16'd1) begin
            errors++;
            $display("FAIL midrst_alone: got valid=%b count=%0d expected valid=0 count=1",
                     out_valid, issue_count);
        end
    endtask

`ifdef MUL32_PACKER_ZERO_FLAG_EN
    task automatic test_zero_flag();
        do_reset();
        #1;
        checks++;
        if (out_zero !== 1'b0) begin
            errors++; $display("FAIL zero_empty_reset: got %b expected 0", out_zero);
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a = 32'h0; in_b = 32'hFFFFFFFF;
        tick();
        in_a = 32'h1; in_b = 32'h1;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_zero !== 1'b1) begin
            errors++; $display("FAIL zero_a0: got %b expected 1", out_zero);
        end
        $display("zero flag A=0: out_zero=%b", out_zero);
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_zero !== 1'b0) begin
            errors++; $display("FAIL zero_a1b1: got %b expected 0", out_zero);
        end
        $display("zero flag A=1 B=1: out_zero=%b", out_zero);
        tick();
        checks++;
        if (out_zero !== 1'b0) begin
            errors++; $display("FAIL zero_empty: got %b expected 0", out_zero);
        end
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_full_pop_push();
        test_stream();
        test_midreset();
`ifdef MUL32_PACKER_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
